// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    typedef enum logic [0:0] {
        StReq  = 1'b0,
        StExec = 1'b1
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;
    localparam int unsigned IMEM_AW_DEFAULT  = 10;
    localparam logic [31:0] NOP              = 32'h0000_0000;

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory req/ack bus between the fetch stage (master) and memory (slave).
interface fetch_if #(
    parameter int unsigned AW = 10
) ();

    logic          req;
    logic [AW-1:0] addr;
    logic          ack;
    logic [31:0]   rdata;

    modport master (
        output req,
        output addr,
        input  ack,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output ack,
        output rdata
    );

endinterface

// File: rtl/next_pc_mux.sv
// Next-PC selection: jumpR over jump over taken branch over sequential.
module next_pc_mux (
    input  logic [31:0] pc_plus4_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] jr_target_i,
    input  logic        pcsrc_i,
    input  logic        jump_i,
    input  logic        jumpr_i,
    output logic [31:0] next_pc_o
);

    logic [31:0] br_off;
    logic        unused_bits;

    assign br_off      = {{14{instr_i[15]}}, instr_i[15:0], 2'b00};
    assign unused_bits = ^{instr_i[31:26], jr_target_i[1:0]};

    always_comb begin
        next_pc_o = pc_plus4_i;
        if (jumpr_i) begin
            next_pc_o = {jr_target_i[31:2], 2'b00};
        end else if (jump_i) begin
            next_pc_o = {pc_plus4_i[31:28], instr_i[25:0], 2'b00};
        end else if (pcsrc_i) begin
            next_pc_o = pc_plus4_i + br_off;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: holds PC, fetches over req/ack, presents the instruction for one EXEC phase.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned IMEM_AW  = IMEM_AW_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    fetch_if.master      imem,
    output logic [31:0]  instr_o,
    output logic [5:0]   op_o,
    output logic [5:0]   funct_o,
    output logic         instr_valid_o,
    output logic [31:0]  pc_o,
    output logic [31:0]  pc_plus4_o,
    input  logic         pcsrc_i,
    input  logic         jump_i,
    input  logic         jumpr_i,
    input  logic [31:0]  jr_target_i,
    input  logic         stall_i,
    output logic [31:0]  instr_count_o
);

    fetch_state_e state_q;
    logic [31:0]  pc_q;
    logic [31:0]  pc_d;
    logic [31:0]  instr_q;
    logic [31:0]  count_q;
    logic [31:0]  pc_plus4;

    assign pc_plus4 = pc_q + 32'd4;

    next_pc_mux u_next_pc_mux (
        .pc_plus4_i  (pc_plus4),
        .instr_i     (instr_q),
        .jr_target_i (jr_target_i),
        .pcsrc_i     (pcsrc_i),
        .jump_i      (jump_i),
        .jumpr_i     (jumpr_i),
        .next_pc_o   (pc_d)
    );

    // Reset wins over a coincident ack, so a fetch in flight is simply dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StReq;
            pc_q    <= RESET_PC;
            instr_q <= NOP;
            count_q <= 32'd0;
        end else begin
            unique case (state_q)
                StReq: begin
                    if (imem.ack) begin
                        instr_q <= imem.rdata;
                        state_q <= StExec;
                    end
                end
                StExec: begin
                    if (!stall_i) begin
                        pc_q    <= pc_d;
                        count_q <= count_q + 32'd1;
                        state_q <= StReq;
                    end
                end
                default: state_q <= StReq;
            endcase
        end
    end

    assign imem.req      = (state_q == StReq) && !reset;
    assign imem.addr     = pc_q[IMEM_AW+1:2];
    assign instr_o       = instr_q;
    assign op_o          = instr_q[31:26];
    assign funct_o       = instr_q[5:0];
    assign instr_valid_o = (state_q == StExec);
    assign pc_o          = pc_q;
    assign pc_plus4_o    = pc_plus4;
    assign instr_count_o = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit; the bench plays instruction memory and the controller.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0040_0000;
    localparam logic [31:0] JUNK   = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr, pc, pc_plus4, instr_count, jr_target;
    logic [5:0]  op, funct;
    logic        instr_valid, pcsrc, jump, jumpr, stall;

    fetch_if #(.AW(10)) imem_bus ();

    fetch_unit #(
        .RESET_PC (RST_PC),
        .IMEM_AW  (10)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .imem          (imem_bus),
        .instr_o       (instr),
        .op_o          (op),
        .funct_o       (funct),
        .instr_valid_o (instr_valid),
        .pc_o          (pc),
        .pc_plus4_o    (pc_plus4),
        .pcsrc_i       (pcsrc),
        .jump_i        (jump),
        .jumpr_i       (jumpr),
        .jr_target_i   (jr_target),
        .stall_i       (stall),
        .instr_count_o (instr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } sb_t;

    sb_t         sb_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    logic [31:0] model_pc;
    logic [31:0] model_cnt;
    logic [31:0] cur_instr;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_next(input logic [31:0] cpc, input logic [31:0] ins,
                                               input logic br, input logic j, input logic jr,
                                               input logic [31:0] jrt);
        logic [31:0] p4;
        logic [31:0] off;
        p4  = cpc + 32'd4;
        off = {{14{ins[15]}}, ins[15:0], 2'b00};
        if (jr)      return {jrt[31:2], 2'b00};
        else if (j)  return {p4[31:28], ins[25:0], 2'b00};
        else if (br) return p4 + off;
        else         return p4;
    endfunction

    // Entered and left on a negedge; on entry the DUT is in REQ.
    task automatic fetch(input logic [31:0] word, input int waits);
        sb_t e;
        for (int i = 0; i < waits; i++) begin
            imem_bus.ack   = 1'b0;
            imem_bus.rdata = JUNK ^ i;
            @(negedge clk);
            check_eq("wait_req", {31'd0, imem_bus.req}, 32'd1);
            check_eq("wait_addr", {22'd0, imem_bus.addr}, {22'd0, model_pc[11:2]});
            check_eq("wait_valid", {31'd0, instr_valid}, 32'd0);
        end
        check_eq("req_addr", {22'd0, imem_bus.addr}, {22'd0, model_pc[11:2]});
        imem_bus.ack   = 1'b1;
        imem_bus.rdata = word;
        sb_q.push_back('{pc: model_pc, instr: word});
        @(negedge clk);
        imem_bus.ack   = 1'b0;
        imem_bus.rdata = JUNK;
        check_eq("exec_valid", {31'd0, instr_valid}, 32'd1);
        check_eq("exec_req", {31'd0, imem_bus.req}, 32'd0);
        if (sb_q.size() == 0) begin
            check_eq("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            cur_instr = e.instr;
            check_eq("sb_instr", instr, e.instr);
            check_eq("sb_pc", pc, e.pc);
            check_eq("op", {26'd0, op}, {26'd0, e.instr[31:26]});
            check_eq("funct", {26'd0, funct}, {26'd0, e.instr[5:0]});
            check_eq("pc_plus4", pc_plus4, e.pc + 32'd4);
        end
    endtask

    // Entered in EXEC; holds for nstall cycles (with stray acks), then retires.
    task automatic exec(input logic br, input logic j, input logic jr, input logic [31:0] jrt,
                        input int nstall);
        for (int i = 0; i < nstall; i++) begin
            stall          = 1'b1;
            imem_bus.ack   = 1'b1;
            imem_bus.rdata = JUNK;
            @(negedge clk);
            check_eq("stall_pc", pc, model_pc);
            check_eq("stall_instr", instr, cur_instr);
            check_eq("stall_cnt", instr_count, model_cnt);
            check_eq("stall_valid", {31'd0, instr_valid}, 32'd1);
        end
        imem_bus.ack = 1'b0;
        stall        = 1'b0;
        pcsrc        = br;
        jump         = j;
        jumpr        = jr;
        jr_target    = jrt;
        model_pc     = model_next(model_pc, cur_instr, br, j, jr, jrt);
        model_cnt    = model_cnt + 32'd1;
        @(negedge clk);
        {pcsrc, jump, jumpr} = 3'b000;
        jr_target = 32'd0;
        check_eq("ret_pc", pc, model_pc);
        check_eq("ret_cnt", instr_count, model_cnt);
        check_eq("ret_req", {31'd0, imem_bus.req}, 32'd1);
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_pc"}, pc, RST_PC);
        check_eq({tag, "_instr"}, instr, 32'd0);
        check_eq({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
        check_eq({tag, "_req"}, {31'd0, imem_bus.req}, 32'd0);
        check_eq({tag, "_cnt"}, instr_count, 32'd0);
        check_eq({tag, "_addr"}, {22'd0, imem_bus.addr}, 32'd0);
        check_eq({tag, "_p4"}, pc_plus4, RST_PC + 32'd4);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        reset = 1'b1;
        {pcsrc, jump, jumpr, stall} = 4'b0000;
        jr_target      = 32'd0;
        imem_bus.ack   = 1'b0;
        imem_bus.rdata = 32'd0;
        model_pc  = RST_PC;
        model_cnt = 32'd0;
        cur_instr = 32'd0;

        @(negedge clk);
        check_reset_state("rst1");
        @(negedge clk);
        check_reset_state("rst2");
        reset = 1'b0;
        @(negedge clk);
        check_eq("post_rst_req", {31'd0, imem_bus.req}, 32'd1);
        check_eq("post_rst_addr", {22'd0, imem_bus.addr}, 32'd0);

        fetch(32'h2008_0005, 0);
        check_eq("addi_op", {26'd0, op}, 32'h08);
        exec(1'b0, 1'b0, 1'b0, 32'd0, 0);
        check_eq("seq_pc", pc, 32'h0040_0004);
        check_eq("seq_cnt", instr_count, 32'd1);

        t0 = cyc;
        for (int k = 0; k < 3; k++) begin
            fetch(32'h0000_0020 + k, 0);
            exec(1'b0, 1'b0, 1'b0, 32'd0, 0);
        end
        check_eq("rate", cyc - t0, 32'd6);

        fetch(32'h1000_FFFF, 3);
        exec(1'b1, 1'b0, 1'b0, 32'd0, 0);
        check_eq("br_neg", pc, 32'h0040_0010);

        fetch(32'h1000_0003, 0);
        exec(1'b1, 1'b0, 1'b0, 32'd0, 0);
        check_eq("br_pos", pc, 32'h0040_0020);

        fetch(32'h0810_0000, 1);
        exec(1'b1, 1'b1, 1'b0, 32'd0, 0);
        check_eq("jump_pri", pc, 32'h0040_0000);

        fetch(32'h0000_0008, 0);
        exec(1'b0, 1'b1, 1'b1, 32'h0040_0023, 4);
        check_eq("jr_pri", pc, 32'h0040_0020);

        check_eq("pre_rst_req", {31'd0, imem_bus.req}, 32'd1);
        reset          = 1'b1;
        imem_bus.ack   = 1'b1;
        imem_bus.rdata = 32'h1234_5678;
        @(negedge clk);
        imem_bus.ack = 1'b0;
        check_reset_state("midrst");
        reset     = 1'b0;
        model_pc  = RST_PC;
        model_cnt = 32'd0;
        @(negedge clk);
        check_eq("midrst_req", {31'd0, imem_bus.req}, 32'd1);

        fetch(32'h0000_0000, 2);
        exec(1'b0, 1'b0, 1'b0, 32'd0, 0);
        check_eq("resume_pc", pc, 32'h0040_0004);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the MIPS core, directly upstream of the decode controller. Holds the PC, fetches each instruction from instruction memory over a req/ack handshake, and presents the latched instruction (op, funct) to the controller. Consumes the controller's `pcsrc`, `jump` and `jumpR` outputs to form the next PC, and retires one instruction per EXEC exit.

## Interface
- `RESET_PC`, 32'h0040_0000, PC value loaded on reset
- `IMEM_AW`, 10, instruction-memory word-address width
- `clk`  in  1  system clock; the only clock
- `reset`  in  1  synchronous, active-high
- `imem_req`  out  IMEM_AW? no: 1  fetch request; held until ack
- `imem_addr`  out  IMEM_AW  word address, `pc[IMEM_AW+1:2]`
- `imem_ack`  in  1  `imem_rdata` valid this cycle
- `imem_rdata`  in  32  fetched instruction word
- `instr`  out  32  instruction register
- `op`  out  6  `instr[31:26]`
- `funct`  out  6  `instr[5:0]`
- `instr_valid`  out  1  `instr` is executing this cycle
- `pc`  out  32  address of `instr`
- `pc_plus4`  out  32  `pc + 4`; this is the jal link value
- `pcsrc`  in  1  branch taken (from controller)
- `jump`  in  1  j/jal (from controller)
- `jumpR`  in  1  jr/jalr (from controller)
- `jr_target`  in  32  rs register value for jumpR
- `stall`  in  1  datapath holds the current instruction
- `instr_count`  out  32  retired-instruction counter

## Operation
- FSM states: REQ and EXEC. Reset state is REQ.
- **REQ**
  - `imem_req` = 1 and `imem_addr` from `pc`; both held stable.
  - On `imem_ack`: `instr <= imem_rdata`, go to EXEC.
  - `imem_rdata` is ignored without `imem_ack`.
- **EXEC**
  - `instr_valid` = 1.
  - If `stall`: remain in EXEC with `pc`, `instr` and `instr_count` unchanged. The datapath gates its writes with `~stall`.
  - Else: `pc <= next_pc`, `instr_count <= instr_count + 1` (wraps mod 2^32), go to REQ.
- **next_pc** priority, highest first:
  - `jumpR`: `{jr_target[31:2], 2'b00}`
  - `jump`: `{pc_plus4[31:28], instr[25:0], 2'b00}`
  - `pcsrc`: `pc_plus4 + (sext(instr[15:0]) << 2)`, 32-bit and wrapping
  - otherwise: `pc_plus4`
- `imem_ack` outside REQ is ignored.
- `imem_req` is forced to 0 while `reset` is high.

## Timing
- Reset values:
  - `pc` = RESET_PC; `instr` = 0 (nop); `op` = `funct` = 0
  - `instr_valid` = 0; `imem_req` = 0; `instr_count` = 0
  - `imem_addr` = `RESET_PC[IMEM_AW+1:2]`; `pc_plus4` = RESET_PC + 4
- First cycle after reset release: `imem_req` = 1.
- Ack in the same cycle as req (zero-wait memory): EXEC on the next cycle. Minimum rate is 2 cycles per instruction.
- Each ack wait cycle adds one cycle; each stall cycle adds one cycle.
- `op`, `funct` and `pc_plus4` are combinational from registers, so they are stable for the whole EXEC. The controller's outputs are therefore valid within EXEC.
- Reset mid-operation: a pending REQ is abandoned and an ack in the reset cycle is dropped. Memory must tolerate an ack with no outstanding req.

## Structure
- Shared package `fetch_pkg`:
  - state encoding (REQ, EXEC)
  - default `RESET_PC`
  - `NOP` = 32'h0
- One combinational sub-module, `next_pc_mux`:
  - inputs: `pc_plus4`, `instr`, `jr_target`, `pcsrc`, `jump`, `jumpR`
  - output: `next_pc`
- PC, instruction register, counter and FSM stay in `fetch_unit`.

## Test plan
- **Reset:** hold `reset` 2 cycles -> `pc` = 0x00400000, `instr` = 0, `instr_valid` = 0, `imem_req` = 0 during reset, 1 on the first cycle after release, `imem_addr` = 0.
- **Zero-wait fetch:** ack in the req cycle with rdata 0x20080005 -> next cycle `instr_valid` = 1, `op` = 0x08. After EXEC: `pc` = 0x00400004, `instr_count` = 1. Steady rate is 2 cycles per instruction.
- **Wait states:** ack delayed 3 cycles with junk rdata before ack -> `imem_req` and `imem_addr` stable all 4 cycles, junk never latched, `instr` = acked word.
- **Branches:** `pc` = 0x00400010, `pcsrc` = 1.
  - imm 0xFFFF -> next `pc` = 0x00400010.
  - imm 0x0003 -> next `pc` = 0x00400020.
- **Jump priority:**
  - `jump` = `pcsrc` = 1 with `instr[25:0]` = 0x0100000 -> `pc` = 0x00400000.
  - `jumpR` = `jump` = 1 with `jr_target` = 0x00400023 -> `pc` = 0x00400020.
- **Stall and reset mid-op:**
  - `stall` high 4 cycles in EXEC -> `pc`, `instr` and `instr_count` held; `instr_valid` stays 1.
  - `reset` asserted in REQ coincident with ack -> `instr` = 0, `pc` = RESET_PC, `instr_count` = 0.
